// File: rtl/funct_generator_multi_pipe.sv
// Pipelined signed multiplier with programmable shift, optional rounding and
// output saturation. A single advance strobe moves every stage, bubbles included.
module funct_generator_multi_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 32,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 1,
   parameter int LATENCY    = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enh,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic signed [OUT_WIDTH-1:0]  data_o,
   output logic                         ovf_o
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int QW = PW + 1;
   localparam int NS = LATENCY - 1;

   localparam logic signed [QW-1:0] ONE     = {{(QW-1){1'b0}}, 1'b1};
   localparam logic signed [QW-1:0] RND_ADD = (ROUND != 0) ? ((ONE << SHIFT) >> 1) : {QW{1'b0}};
   localparam logic signed [QW-1:0] Q_MAX   = (ONE << (OUT_WIDTH - 1)) - ONE;
   localparam logic signed [QW-1:0] Q_MIN   = -(ONE << (OUT_WIDTH - 1));

   generate
      if (LATENCY < 2 || OUT_WIDTH < 2 || OUT_WIDTH > PW || SHIFT < 0 || SHIFT > PW - 1) begin : g_bad_param
         $error("funct_generator_multi_pipe: illegal parameter combination");
      end
   endgenerate

   // Round, shift and clamp; the extra product bit keeps the rounding add from wrapping.
   function automatic logic [OUT_WIDTH:0] shift_sat(input logic signed [PW-1:0] p);
      logic signed [QW-1:0] pe;
      logic signed [QW-1:0] q;
      logic [OUT_WIDTH:0]   r;
      pe = $signed({p[PW-1], p}) + RND_ADD;
      q  = pe >>> SHIFT;
      if (q > Q_MAX) begin
         r = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (q < Q_MIN) begin
         r = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         r = {1'b0, q[OUT_WIDTH-1:0]};
      end
      return r;
   endfunction

   logic                 adv_s;
   logic signed [PW-1:0] a_ext_s;
   logic signed [PW-1:0] b_ext_s;
   logic signed [PW-1:0] prod_s;
   logic [OUT_WIDTH:0]   res_s;
   logic signed [PW-1:0] stage_p_r [NS];
   logic [NS-1:0]        stage_v_r;

   // Global advance strobe shared by all stages.
   always_comb begin
      adv_s = enh && (!valid_o || ready_i);
   end

   assign ready_o = adv_s;

   // Full-precision product and last-stage result formatting.
   always_comb begin
      a_ext_s = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
      b_ext_s = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
      prod_s  = a_ext_s * b_ext_s;
      res_s   = shift_sat(stage_p_r[NS-1]);
   end

   // Pipeline registers: product stage, delay stages, registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_v_r <= '0;
         for (int i = 0; i < NS; i++) begin
            stage_p_r[i] <= '0;
         end
         valid_o <= 1'b0;
         data_o  <= '0;
         ovf_o   <= 1'b0;
      end else if (adv_s) begin
         stage_v_r[0] <= valid_i;
         stage_p_r[0] <= prod_s;
         for (int i = 1; i < NS; i++) begin
            stage_v_r[i] <= stage_v_r[i-1];
            stage_p_r[i] <= stage_p_r[i-1];
         end
         valid_o <= stage_v_r[NS-1];
         // Bubbles leave a clean zero on the output rather than stale data.
         if (stage_v_r[NS-1]) begin
            data_o <= res_s[OUT_WIDTH-1:0];
            ovf_o  <= res_s[OUT_WIDTH];
         end else begin
            data_o <= '0;
            ovf_o  <= 1'b0;
         end
      end else begin
         valid_o <= valid_o;
         data_o  <= data_o;
         ovf_o   <= ovf_o;
      end
   end

endmodule

// File: doc/funct_generator_multi_pipe.md
Name: funct_generator_multi_pipe

Overview:
- Pipelined, parametrised signed multiplier for the function-generator datapath.
- Accepts operand pairs through a valid/ready handshake and computes the full-precision product.
- Applies a programmable right shift with optional rounding, then saturates to a configurable output width.
- Sits between the function-generator sources and the output FIFO; back-pressure from the FIFO stalls the whole pipeline without losing data.

Parameters:
- DATA_WIDTH, 32: signed width of each operand.
- OUT_WIDTH, 32: signed width of the result. Range 2..2*DATA_WIDTH.
- SHIFT, 0: arithmetic right shift applied to the full product. Range 0..2*DATA_WIDTH-1.
- ROUND, 1: 1 = add 2^(SHIFT-1) before shifting (round half toward +inf); 0 = truncate. Ignored when SHIFT=0.
- LATENCY, 3: pipeline depth in cycles from input acceptance to valid_o. Minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- enh  in  1  pipeline enable; 0 freezes all stages (no accept, no advance, outputs held).
- valid_i  in  1  operands a_i/b_i valid.
- ready_o  out  1  block can accept operands this cycle.
- a_i  in  DATA_WIDTH  signed operand A.
- b_i  in  DATA_WIDTH  signed operand B.
- valid_o  out  1  data_o/ovf_o valid.
- ready_i  in  1  downstream accepts the result.
- data_o  out  OUT_WIDTH  signed, shifted, rounded, saturated product.
- ovf_o  out  1  result was saturated; qualified by valid_o.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits clear; valid_o=0, data_o=0, ovf_o=0. ready_o=enh combinationally. rst overrides enh. In-flight data is discarded.
- Advance condition: adv = enh && (!valid_o || ready_i). When adv=1, every stage shifts one position, including empty stages (bubbles). When adv=0, all stage registers hold.
- ready_o = adv (combinational, no dependency on valid_i).
- A transfer occurs when valid_i && ready_o. A new sample enters stage 1 with valid=1. If ready_o=1 and valid_i=0, a bubble (valid=0) enters.
- Output transfer occurs when valid_o && ready_i. An output is held stable while valid_o=1 and ready_i=0.
- Latency: a sample accepted at edge N appears on valid_o after edge N+LATENCY-1 with no stall, so it is visible during cycle N+LATENCY-1. Each stall cycle adds one cycle.
- Throughput: one result per cycle when ready_i=1 continuously.
- Stage 1 registers the full signed product p = a_i*b_i, width 2*DATA_WIDTH. The most negative times most negative case is exact.
- Last stage:
  - q = (p + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in 2*DATA_WIDTH+1 bits so the rounding add cannot wrap.
  - If q > 2^(OUT_WIDTH-1)-1: data_o = max positive, ovf_o=1.
  - Else if q < -2^(OUT_WIDTH-1): data_o = min negative, ovf_o=1.
  - Else data_o = q, ovf_o=0.
- Intermediate stages between these two are pure delay registers. They are available to the synthesiser for retiming.
- Simultaneous output pop and input push in the same cycle with the pipeline full: both occur, with no bubble inserted.
- enh=0 mid-stream: the pipeline freezes; valid_o and data_o hold their values even if ready_i=1. The downstream must not consume while enh=0; valid_o stays asserted.
- Invalid parameter values (LATENCY<2, OUT_WIDTH>2*DATA_WIDTH) are rejected by an elaboration-time assertion.

Test Plan (DATA_WIDTH=8, OUT_WIDTH=8, SHIFT=4, ROUND=1, LATENCY=3 unless noted):
- Basic: a=12, b=10, single valid pulse, ready_i=1 -> valid_o high 2 cycles after acceptance, data_o=8, ovf_o=0.
- Negative rounding: a=-3, b=5 -> data_o=-1 (0xFF), ovf_o=0. Same operands with ROUND=0 -> data_o=-1. Then a=-1, b=8 with ROUND=1 -> data_o=0 (-8+8=0).
- Saturation: a=-128, b=-128 -> data_o=127, ovf_o=1. Then a=-128, b=127 -> data_o=-128, ovf_o=1.
- Back-pressure: stream 10 back-to-back pairs (a=i, b=16, i=1..10) with ready_i toggled in a 1-0-0-1 pattern -> exactly 10 outputs in order, data_o=i, no drops or duplicates, ready_o low exactly while valid_o=1 and ready_i=0.
- Enable freeze: with 3 samples in flight, drop enh for 4 cycles -> ready_o=0 and valid_o/data_o held. On re-enable, results resume in order with no loss.
- Reset mid-operation: assert rst for 1 cycle with the pipeline full -> next cycle valid_o=0, data_o=0, ovf_o=0. The first result after reset comes from the first pair accepted post-reset.
